// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath:
// instruction fields and flags in, mux selects, enables and debug status out.
interface mc_ctrl_if;
    logic [6:0]  Op;
    logic [2:0]  Funct3;
    logic        Funct7b5;
    logic        Zero;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;
    logic        Illegal;
    logic [31:0] Retired;

    // Controller side
    modport master (
        input  Op, Funct3, Funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State, Illegal, Retired
    );

    // Datapath side
    modport slave (
        output Op, Funct3, Funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State, Illegal, Retired
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle RV32 subset controller: Moore FSM with ALU/immediate decoders,
// sticky illegal-opcode flag and retired-instruction counter.
module mc_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] retired_r;
    logic        illegal_r;

    logic        pc_update_s;
    logic        branch_s;
    logic        adr_src_s;
    logic        mem_write_s;
    logic        ir_write_s;
    logic        reg_write_s;
    logic [1:0]  result_src_s;
    logic [1:0]  alu_src_a_s;
    logic [1:0]  alu_src_b_s;
    logic [1:0]  alu_op_s;
    logic [2:0]  alu_control_s;
    logic [1:0]  imm_src_s;
    logic        retire_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= state_t'(RESET_STATE);
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; unused codes 12-15 fall through to FETCH
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:    next_state_s = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    7'b0000011, 7'b0100011: next_state_s = S_MEMADR;
                    7'b0110011:             next_state_s = S_EXECUTER;
                    7'b0010011:             next_state_s = S_EXECUTEI;
                    7'b1100011:             next_state_s = S_BEQ;
                    7'b1101111:             next_state_s = S_JAL;
                    default:                next_state_s = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (bus.Op[5]) begin
                    next_state_s = S_MEMWRITE;
                end else begin
                    next_state_s = S_MEMREAD;
                end
            end
            S_MEMREAD:  next_state_s = S_MEMWB;
            S_MEMWB:    next_state_s = S_FETCH;
            S_MEMWRITE: next_state_s = S_FETCH;
            S_EXECUTER: next_state_s = S_ALUWB;
            S_EXECUTEI: next_state_s = S_ALUWB;
            S_JAL:      next_state_s = S_ALUWB;
            S_ALUWB:    next_state_s = S_FETCH;
            S_BEQ:      next_state_s = S_FETCH;
            S_TRAP:     next_state_s = S_TRAP;
            default:    next_state_s = S_FETCH;
        endcase
    end

    // Moore output decode per state
    always_comb begin
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        case (state_r)
            S_FETCH: begin
                ir_write_s   = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                pc_update_s  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_MEMREAD:  adr_src_s = 1'b1;
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b10;
            end
            S_ALUWB:    reg_write_s = 1'b1;
            S_BEQ: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b01;
                branch_s    = 1'b1;
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
            end
            default: begin
                pc_update_s = 1'b0;
            end
        endcase
    end

    // ALU operation decode; subtract only for R-type with Funct7b5 set
    always_comb begin
        alu_control_s = 3'b000;
        case (alu_op_s)
            2'b00: alu_control_s = 3'b000;
            2'b01: alu_control_s = 3'b001;
            2'b10: begin
                case (bus.Funct3)
                    3'b000: begin
                        if (bus.Op[5] && bus.Funct7b5) begin
                            alu_control_s = 3'b001;
                        end else begin
                            alu_control_s = 3'b000;
                        end
                    end
                    3'b010:  alu_control_s = 3'b101;
                    3'b110:  alu_control_s = 3'b011;
                    3'b111:  alu_control_s = 3'b010;
                    default: alu_control_s = 3'b111;
                endcase
            end
            default: alu_control_s = 3'b000;
        endcase
    end

    // Immediate format decode
    always_comb begin
        imm_src_s = 2'b00;
        case (bus.Op)
            7'b0100011: imm_src_s = 2'b01;
            7'b1100011: imm_src_s = 2'b10;
            7'b1101111: imm_src_s = 2'b11;
            default:    imm_src_s = 2'b00;
        endcase
    end

    assign retire_s = (state_r == S_MEMWB) || (state_r == S_MEMWRITE) ||
                      (state_r == S_ALUWB) || (state_r == S_BEQ);

    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_r <= 32'd0;
        end else if (retire_s) begin
            retired_r <= retired_r + 32'd1;
        end
    end

    // Sticky illegal flag, set on the edge that enters TRAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_r <= 1'b0;
        end else if (next_state_s == S_TRAP) begin
            illegal_r <= 1'b1;
        end
    end

    // Write enables are held off for the whole reset interval
    assign bus.PCWrite    = ~rst & (pc_update_s | (branch_s & bus.Zero));
    assign bus.IRWrite    = ~rst & ir_write_s;
    assign bus.RegWrite   = ~rst & reg_write_s;
    assign bus.MemWrite   = ~rst & mem_write_s;
    assign bus.AdrSrc     = adr_src_s;
    assign bus.ResultSrc  = result_src_s;
    assign bus.ALUSrcA    = alu_src_a_s;
    assign bus.ALUSrcB    = alu_src_b_s;
    assign bus.ImmSrc     = imm_src_s;
    assign bus.ALUControl = alu_control_s;
    assign bus.State      = state_r;
    assign bus.Illegal    = illegal_r;
    assign bus.Retired    = retired_r;

endmodule
